// File: rtl/fx2_in_arbiter_if.sv
// Byte-stream bundle between the sample source, reply source, the FX2 IN port and the arbiter.
// master = arbiter side, slave = surrounding sources/sink.
interface fx2_in_arbiter_if;
    logic       sample_rdy;
    logic [7:0] sample;
    logic       sample_ack;
    logic       reply_rdy;
    logic [7:0] reply;
    logic       reply_end;
    logic       reply_ack;
    logic       out_rdy;
    logic [7:0] out_data;
    logic       out_ack;
    logic       out_pktend;
    logic [1:0] grant;

    modport master (
        input  sample_rdy, sample, reply_rdy, reply, reply_end, out_ack,
        output sample_ack, reply_ack, out_rdy, out_data, out_pktend, grant
    );

    modport slave (
        output sample_rdy, sample, reply_rdy, reply, reply_end, out_ack,
        input  sample_ack, reply_ack, out_rdy, out_data, out_pktend, grant
    );
endinterface

// File: rtl/fx2_in_arbiter.sv
// Packet-level arbiter sharing the FX2 IN byte stream between timetag samples and command replies.
// Registered grant state, combinational data path; requests a pktend whenever a short packet must close.
module fx2_in_arbiter #(
    parameter int unsigned BURST         = 512,
    parameter int unsigned FLUSH_TIMEOUT = 4096
) (
    input logic              fx2_clk,
    input logic              rst_n,
    fx2_in_arbiter_if.master bus
);
    localparam int unsigned CNT_W   = $clog2(BURST) + 1;
    localparam int unsigned IDLE_W  = (FLUSH_TIMEOUT < 2) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
    localparam int unsigned TO_LAST = (FLUSH_TIMEOUT == 0) ? 0 : FLUSH_TIMEOUT - 1;

    typedef enum logic [1:0] {IDLE, SAMPLE, REPLY, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    pkt_cnt;
    logic [IDLE_W-1:0]   idle_cnt;

    logic                out_rdy, sample_ack, reply_ack, out_pktend;
    logic [7:0]          out_data;
    logic [1:0]          grant;
    logic                xfer, pkt_last, idle_hit;

    assign xfer     = out_rdy & bus.out_ack;
    assign pkt_last = (pkt_cnt == CNT_W'(BURST - 1));
    // True on the idle cycle that brings the idle run up to the timeout
    assign idle_hit = (FLUSH_TIMEOUT != 0) && !bus.sample_rdy && (idle_cnt >= IDLE_W'(TO_LAST));

    always_ff @(posedge fx2_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        out_rdy    = 1'b0;
        out_data   = 8'h00;
        sample_ack = 1'b0;
        reply_ack  = 1'b0;
        out_pktend = 1'b0;
        grant      = 2'b00;
        case (state_q)
            IDLE: begin
                if (bus.reply_rdy)       state_d = REPLY;
                else if (bus.sample_rdy) state_d = SAMPLE;
            end
            SAMPLE: begin
                grant      = 2'b01;
                out_rdy    = bus.sample_rdy;
                out_data   = bus.sample;
                sample_ack = bus.out_ack & bus.sample_rdy;
                // Full packet is committed by the FX2 itself; the boundary lets a reply in
                if (sample_ack && pkt_last)
                    state_d = IDLE;
                else if (!bus.sample_rdy && (pkt_cnt != '0) && (bus.reply_rdy || idle_hit))
                    state_d = FLUSH;
                else if (!bus.sample_rdy && (pkt_cnt == '0) && bus.reply_rdy)
                    state_d = IDLE;
            end
            REPLY: begin
                grant     = 2'b10;
                out_rdy   = bus.reply_rdy;
                out_data  = bus.reply;
                reply_ack = bus.out_ack & bus.reply_rdy;
                if (reply_ack && bus.reply_end) state_d = FLUSH;
            end
            FLUSH: begin
                out_pktend = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bytes of the packet currently open in the FX2 buffer
    always_ff @(posedge fx2_clk or negedge rst_n) begin
        if (!rst_n)                pkt_cnt <= '0;
        else if (state_q == FLUSH) pkt_cnt <= '0;
        else if (xfer)             pkt_cnt <= pkt_last ? '0 : pkt_cnt + CNT_W'(1);
    end

    always_ff @(posedge fx2_clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if ((state_q != SAMPLE) || (state_d != SAMPLE) || bus.sample_rdy)
            idle_cnt <= '0;
        else if (idle_cnt != IDLE_W'(FLUSH_TIMEOUT))
            idle_cnt <= idle_cnt + IDLE_W'(1);
    end

    assign bus.out_rdy    = out_rdy;
    assign bus.out_data   = out_data;
    assign bus.sample_ack = sample_ack;
    assign bus.reply_ack  = reply_ack;
    assign bus.out_pktend = out_pktend;
    assign bus.grant      = grant;
endmodule

// File: tb/tb_fx2_in_arbiter.sv
// Directed bench for fx2_in_arbiter with BURST=8, FLUSH_TIMEOUT=16.
// Sources advance on the DUT acks; expected outputs are hand-computed per cycle.
module tb_fx2_in_arbiter;
    localparam int unsigned BURST         = 8;
    localparam int unsigned FLUSH_TIMEOUT = 16;

    logic fx2_clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    // Source models
    logic       s_en, r_en, ack_en;
    int         sent, ri, rlen;
    logic [7:0] rbase;

    fx2_in_arbiter_if bus();

    fx2_in_arbiter #(.BURST(BURST), .FLUSH_TIMEOUT(FLUSH_TIMEOUT)) dut (
        .fx2_clk (fx2_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 fx2_clk = ~fx2_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.sample_rdy = s_en;
        bus.sample     = 8'(8'h40 + sent);
        bus.reply_rdy  = r_en && (ri < rlen);
        bus.reply      = 8'(rbase + 8'(ri));
        bus.reply_end  = r_en && (ri == rlen - 1);
        bus.out_ack    = ack_en;
    endtask

    task automatic chk_all(input string tag, input logic e_rdy, input logic [7:0] e_data,
                           input logic e_sack, input logic e_rack, input logic e_pend,
                           input logic [1:0] e_gnt);
        chk({tag, ".out_rdy"},    32'(bus.out_rdy),    32'(e_rdy));
        chk({tag, ".out_data"},   32'(bus.out_data),   32'(e_data));
        chk({tag, ".sample_ack"}, 32'(bus.sample_ack), 32'(e_sack));
        chk({tag, ".reply_ack"},  32'(bus.reply_ack),  32'(e_rack));
        chk({tag, ".out_pktend"}, 32'(bus.out_pktend), 32'(e_pend));
        chk({tag, ".grant"},      32'(bus.grant),      32'(e_gnt));
    endtask

    // One clock cycle: drive, settle, check, let sources consume, move to next cycle
    task automatic cyc(input string tag, input logic e_rdy, input logic [7:0] e_data,
                       input logic e_sack, input logic e_rack, input logic e_pend,
                       input logic [1:0] e_gnt);
        drive();
        #1;
        chk_all(tag, e_rdy, e_data, e_sack, e_rack, e_pend, e_gnt);
        if (bus.sample_ack === 1'b1) sent++;
        if (bus.reply_ack === 1'b1)  ri++;
        @(posedge fx2_clk);
        #2;
    endtask

    task automatic new_reply(input logic [7:0] base, input int len);
        rbase = base;
        rlen  = len;
        ri    = 0;
        r_en  = 1'b1;
    endtask

    initial begin
        int npend;
        rst_n  = 1'b0;
        s_en   = 1'b0;
        r_en   = 1'b0;
        ack_en = 1'b0;
        sent   = 0;
        ri     = 0;
        rlen   = 0;
        rbase  = 8'h00;
        drive();
        #1;
        chk_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("reset.pkt_cnt",  32'(dut.pkt_cnt),  32'd0);
        chk("reset.idle_cnt", 32'(dut.idle_cnt), 32'd0);
        repeat (2) @(posedge fx2_clk);
        #2;
        rst_n  = 1'b1;
        ack_en = 1'b1;

        // Sample-only: 20 bytes, IDLE slot at each burst boundary
        s_en = 1'b1;
        for (int c = 0; c < 23; c++) begin
            if (c % 9 == 0) cyc($sformatf("s1_c%0d", c), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
            else            cyc($sformatf("s1_c%0d", c), 1'b1, 8'(8'h40 + c - c / 9 - 1),
                                1'b1, 1'b0, 1'b0, 2'b01);
        end
        // Partial packet of 4 then idle: pktend only after the 16-cycle timeout
        s_en = 1'b0;
        for (int i = 1; i <= 16; i++)
            cyc($sformatf("to_idle%0d", i), 1'b0, 8'h54, 1'b0, 1'b0, 1'b0, 2'b01);
        npend = 0;
        for (int i = 0; i < 6; i++) begin
            drive();
            #1;
            if (bus.out_pktend === 1'b1) begin
                npend++;
                chk("to_pend.out_rdy", 32'(bus.out_rdy), 32'd0);
            end
            @(posedge fx2_clk);
            #2;
        end
        chk("to_pktend_count", 32'(npend), 32'd1);
        cyc("to_after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);

        // Simultaneous requests: reply wins, then FLUSH, IDLE, SAMPLE
        s_en = 1'b1;
        new_reply(8'hA0, 3);
        cyc("s2_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("s2_r0",   1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 2'b10);
        cyc("s2_r1",   1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 2'b10);
        cyc("s2_r2",   1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 2'b10);
        cyc("s2_flush",1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00);
        cyc("s2_gap",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int k = 0; k < 5; k++)
            cyc($sformatf("s2_s%0d", k), 1'b1, 8'(8'h54 + k), 1'b1, 1'b0, 1'b0, 2'b01);

        // Reply pending while samples keep flowing: held off until byte 8
        new_reply(8'hD0, 1);
        for (int k = 0; k < 3; k++)
            cyc($sformatf("s3a_s%0d", k), 1'b1, 8'(8'h59 + k), 1'b1, 1'b0, 1'b0, 2'b01);
        cyc("s3a_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("s3a_r0",   1'b1, 8'hD0, 1'b0, 1'b1, 1'b0, 2'b10);
        cyc("s3a_flush",1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00);
        cyc("s3a_gap",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int k = 0; k < 5; k++)
            cyc($sformatf("s3b_s%0d", k), 1'b1, 8'(8'h5C + k), 1'b1, 1'b0, 1'b0, 2'b01);

        // Sample stalls mid-packet with reply pending: FLUSH, IDLE, REPLY
        s_en = 1'b0;
        new_reply(8'hE0, 2);
        cyc("s3b_dec",  1'b0, 8'h61, 1'b0, 1'b0, 1'b0, 2'b01);
        cyc("s3b_flush",1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00);
        cyc("s3b_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("s3b_r0",   1'b1, 8'hE0, 1'b0, 1'b1, 1'b0, 2'b10);
        cyc("s3b_r1",   1'b1, 8'hE1, 1'b0, 1'b1, 1'b0, 2'b10);
        cyc("s3b_rfl",  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00);
        cyc("s3b_end",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);

        // Reply at packet boundary: SAMPLE with pkt_cnt=0 goes to IDLE, no pktend
        s_en = 1'b1;
        cyc("s4_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        s_en = 1'b0;
        new_reply(8'hB0, 4);
        cyc("s4_samp", 1'b0, 8'h61, 1'b0, 1'b0, 1'b0, 2'b01);
        cyc("s4_idl2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("s4_r0",   1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 2'b10);

        // Backpressure: 10 cycles without out_ack mid-reply
        ack_en = 1'b0;
        for (int k = 0; k < 10; k++)
            cyc($sformatf("s5_bp%0d", k), 1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 2'b10);
        ack_en = 1'b1;
        cyc("s5_r1",   1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 2'b10);
        cyc("s5_r2",   1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 2'b10);
        cyc("s5_r3",   1'b1, 8'hB3, 1'b0, 1'b1, 1'b0, 2'b10);
        cyc("s5_flush",1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00);
        cyc("s5_end",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);

        // Reset after 2 of 4 reply bytes
        new_reply(8'hC0, 4);
        cyc("s6_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc("s6_r0",   1'b1, 8'hC0, 1'b0, 1'b1, 1'b0, 2'b10);
        cyc("s6_r1",   1'b1, 8'hC1, 1'b0, 1'b1, 1'b0, 2'b10);
        drive();
        #1;
        chk("s6_pre.out_rdy", 32'(bus.out_rdy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all("s6_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("s6_rst.pkt_cnt", 32'(dut.pkt_cnt), 32'd0);
        repeat (2) @(posedge fx2_clk);
        #2;
        rst_n = 1'b1;
        cyc("s6_rel",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("s6_rel.pkt_cnt", 32'(dut.pkt_cnt), 32'd0);
        cyc("s6_r2",   1'b1, 8'hC2, 1'b0, 1'b1, 1'b0, 2'b10);
        chk("s6_r2.pkt_cnt", 32'(dut.pkt_cnt), 32'd1);
        cyc("s6_r3",   1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 2'b10);
        cyc("s6_flush",1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00);
        cyc("s6_end",  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fx2_in_arbiter.md
# fx2_in_arbiter

Packet-level arbiter sharing the single FX2 IN byte stream between the timetag sample stream and the command-reply stream. It sits between the timetag core (samples), the command decoder (replies) and the FX2 bidirectional interface. It grants one source at a time, cuts sample traffic into full FX2 packets, and requests a packet-end commit whenever a short packet must close: reply end, source switch, or sample-stream idle timeout.

## Interface
- BURST, 512: FX2 IN packet size in bytes; power of two, 2..1024.
- FLUSH_TIMEOUT, 4096: idle cycles before a partial sample packet is committed; 0 disables the timeout.
- fx2_clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sample_rdy  in  1  sample byte valid.
- sample  in  8  sample byte.
- sample_ack  out  1  sample byte consumed this cycle.
- reply_rdy  in  1  reply byte valid.
- reply  in  8  reply byte.
- reply_end  in  1  qualifies the current reply byte as the last of its message.
- reply_ack  out  1  reply byte consumed this cycle.
- out_rdy  out  1  byte valid toward the FX2 interface.
- out_data  out  8  byte toward the FX2 interface.
- out_ack  in  1  FX2 interface consumed out_data; meaningful only while out_rdy=1.
- out_pktend  out  1  one-cycle request to commit the current short packet.
- grant  out  2  01 = sample, 10 = reply, 00 = none.

## Operation
- States: IDLE, SAMPLE, REPLY, FLUSH; registered state, combinational data path.
- Data path by state:
  - SAMPLE: out_rdy=sample_rdy, out_data=sample, sample_ack=out_ack&sample_rdy.
  - REPLY: out_rdy=reply_rdy, out_data=reply, reply_ack=out_ack&reply_rdy.
  - All other states: out_rdy=0, out_data=0, both acks 0.
  - A non-granted source never sees ack.
- pkt_cnt: bytes of the current, not yet committed packet, width log2(BURST)+1. Increments on every out_ack while out_rdy=1, in either data state. Cleared on FLUSH exit and when the count reaches BURST (FX2 auto-commits full packets).
- idle_cnt: increments each SAMPLE cycle with sample_rdy=0; cleared on any sample_rdy=1 and on leaving SAMPLE. Saturates at FLUSH_TIMEOUT.
- IDLE transitions, priority order:
  - reply_rdy -> REPLY.
  - sample_rdy -> SAMPLE.
  - Otherwise stay.
  - Reply wins simultaneous requests.
- SAMPLE transitions:
  - Ack of byte BURST of the packet -> IDLE. pkt_cnt clears and no pktend is issued. This burst boundary gives pending replies a slot.
  - sample_rdy=0 and pkt_cnt>0 and (reply_rdy=1 or idle_cnt reaching FLUSH_TIMEOUT with FLUSH_TIMEOUT≠0) -> FLUSH.
  - sample_rdy=0 and pkt_cnt=0 and reply_rdy=1 -> IDLE.
  - Otherwise stay.
- REPLY transitions:
  - Ack of a byte with reply_end=1 -> FLUSH. This applies even if that byte filled the packet: the pktend then commits a zero-length packet, which the host treats as message delimiter.
  - Otherwise stay. Replies are never preempted.
- FLUSH: lasts exactly one cycle with out_pktend=1, clears pkt_cnt, then -> IDLE.
- grant reflects the state: SAMPLE=01, REPLY=10, else 00.

## Timing
- Reset (asynchronous assert): state IDLE, pkt_cnt=0, idle_cnt=0, out_rdy=0, out_data=0, out_pktend=0, sample_ack=0, reply_ack=0, grant=00. Reset mid-packet discards the partial count and issues no pktend.
- Release takes effect on the first fx2_clk edge with rst_n high.
- Grant latency: a request seen in IDLE at edge N gives out_rdy from cycle N+1.
- Throughput inside a grant: one byte per cycle; acks are combinational, zero-latency.
- out_pktend asserts the cycle after the final reply byte's ack, or the cycle after the timeout/switch decision, and never coincides with out_rdy=1.
- Minimum gap between two reply messages: 2 idle cycles (FLUSH, IDLE).
- A source dropping rdy mid-grant simply stalls; out_rdy follows combinationally.

## Test plan
- Sample-only stream, BURST=8, sample_rdy held high for 20 bytes: bytes pass in order with grant=01. IDLE cycles occur after bytes 8 and 16. No out_pktend. After 4 bytes plus FLUSH_TIMEOUT=16 idle cycles, a single out_pktend pulse occurs.
- sample_rdy and reply_rdy rise in the same cycle: REPLY is granted first. The 3-byte reply ends with reply_end, followed by one out_pktend cycle. Sampling then starts, 2 cycles after the last reply ack.
- Reply arrives while sampling: with 5 bytes sent, reply_rdy=1, then sample_rdy drops. Sequence is FLUSH pulse, IDLE, REPLY. The reply is not granted while sample_rdy stays high, until the burst boundary at byte 8.
- Reply arrives at a packet boundary: pkt_cnt=0, sample_rdy=0, reply_rdy=1 in SAMPLE. Transition is to IDLE, then REPLY, with no out_pktend.
- Backpressure: out_ack held low 10 cycles mid-reply. reply_ack stays 0, out_data stays stable, and no byte is lost or duplicated.
- Reset mid-reply after 2 of 4 bytes: all outputs are 0 immediately. After release, a pending reply_rdy is granted from cycle 2 with pkt_cnt starting at 0.
